// File: rtl/wb_mbox_bridge.sv
// Wishbone classic slave that carries SoC control bits and two 32-bit mailbox FIFOs
// (TX: management to SoC, RX: SoC to management) with a level interrupt on RX data.
module wb_mbox_bridge #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [31:0] rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        soc_rst_no,
  output logic [1:0]  boot_sel_o,
  output logic        irq_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, irq_q, irq_d;
  logic [31:0]      tx_mem_q [DEPTH];
  logic [31:0]      rx_mem_q [DEPTH];
  logic [PW-1:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic [5:0]  off;
  logic        accept, wr, rd;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic [31:0] status, rdata;
  logic        unused_ok;

  assign unused_ok = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_sel_i[3:1]};

  always_comb begin
    off      = wbs_adr_i[7:2];
    accept   = wbs_stb_i & wbs_cyc_i & ~ack_q;
    wr       = accept & wbs_we_i;
    rd       = accept & ~wbs_we_i;
    tx_full  = (tx_cnt_q == FULL_CNT);
    tx_empty = (tx_cnt_q == '0);
    rx_full  = (rx_cnt_q == FULL_CNT);
    rx_empty = (rx_cnt_q == '0);
    // Full/empty decisions use pre-edge occupancy, so a same-cycle SoC pop
    // never rescues a push into a full TX FIFO.
    tx_push  = wr && (off == 6'd2) && !tx_full;
    tx_pop   = !tx_empty && tx_ready_i;
    rx_push  = rx_valid_i && rx_ready_o;
    rx_pop   = rd && (off == 6'd3) && !rx_empty;

    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[7:4]   = 4'(tx_cnt_q);
    status[11:8]  = 4'(rx_cnt_q);
    status[12]    = ovf_q;
    status[13]    = udf_q;

    rdata = '0;
    case (off)
      6'd0: rdata = {28'd0, ctrl_q};
      6'd1: rdata = status;
      6'd3: if (!rx_empty) rdata = rx_mem_q[rx_rp_q];
      default: rdata = '0;
    endcase

    ack_d  = accept;
    dat_d  = rd ? rdata : '0;
    ctrl_d = ctrl_q;
    if (wr && (off == 6'd0) && wbs_sel_i[0]) ctrl_d = wbs_dat_i[3:0];

    ovf_d = ovf_q;
    if (wr && (off == 6'd1) && wbs_dat_i[12]) ovf_d = 1'b0;
    if (wr && (off == 6'd2) && tx_full)       ovf_d = 1'b1;
    udf_d = udf_q;
    if (wr && (off == 6'd1) && wbs_dat_i[13]) udf_d = 1'b0;
    if (rd && (off == 6'd3) && rx_empty)      udf_d = 1'b1;

    tx_wp_d  = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + 1'b1 : tx_rp_q;
    rx_wp_d  = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + 1'b1 : rx_rp_q;
    tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    irq_d    = ctrl_q[3] & ~rx_empty;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      ctrl_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_q    <= 1'b0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      ctrl_q   <= ctrl_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_q    <= irq_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // Storage needs no reset: the pointers and counts define what is valid.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= wbs_dat_i;
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data_i;
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign tx_data_o  = tx_mem_q[tx_rp_q];
  assign tx_valid_o = ~tx_empty;
  assign rx_ready_o = rst_ni & ~rx_full;
  assign soc_rst_no = ctrl_q[0];
  assign boot_sel_o = ctrl_q[2:1];
  assign irq_o      = irq_q;
endmodule

// File: tb/tb_wb_mbox_bridge.sv
// Directed and randomized bench for wb_mbox_bridge, checked against a queue-based
// model of the two mailboxes, the control register and the sticky flags.
module tb_wb_mbox_bridge;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] dat_o;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ready;
  logic        soc_rst_n;
  logic [1:0]  boot_sel;
  logic        irq;

  always #5 clk = ~clk;

  wb_mbox_bridge #(.DEPTH(DEPTH), .CNT_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .soc_rst_no(soc_rst_n), .boot_sel_o(boot_sel), .irq_o(irq)
  );

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  // Reference model
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic [3:0]  m_ctrl;
  logic        m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (tx_q.size() == DEPTH);
    s[1] = (tx_q.size() == 0);
    s[2] = (rx_q.size() == DEPTH);
    s[3] = (rx_q.size() == 0);
    s[7:4] = 4'(tx_q.size());
    s[11:8] = 4'(rx_q.size());
    s[12] = m_ovf;
    s[13] = m_udf;
    return s;
  endfunction

  task automatic m_tx_write(input logic [31:0] d);
    if (tx_q.size() < DEPTH) tx_q.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic m_rx_read(output logic [31:0] e);
    if (rx_q.size() == 0) begin
      m_udf = 1'b1;
      e = '0;
    end else e = rx_q.pop_front();
  endtask

  // One Wishbone access: ack must rise one edge after accept and drop the next.
  task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    chk("ack_rise", {31'd0, ack}, 32'd1);
    r = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("ack_fall", {31'd0, ack}, 32'd0);
    chk("dat_idle", dat_o, 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_cycle(a, 1'b1, d, s, r);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_cycle(a, 1'b0, 32'd0, 4'hf, r);
  endtask

  task automatic do_tx_write(input logic [31:0] d);
    wb_write(32'h08, d, 4'($urandom_range(0, 15)));
    m_tx_write(d);
  endtask

  task automatic do_rx_read();
    logic [31:0] r, e;
    wb_read(32'h0c, r);
    m_rx_read(e);
    chk("rxdata", r, e);
  endtask

  task automatic do_status(input string tag);
    logic [31:0] r;
    wb_read(32'h04, r);
    chk(tag, r, exp_status());
  endtask

  task automatic soc_push(input logic [31:0] d);
    @(negedge clk);
    chk("rx_ready", {31'd0, rx_ready}, {31'd0, rx_q.size() < DEPTH});
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk);
    if (rx_q.size() < DEPTH) rx_q.push_back(d);
    #1 rx_valid = 1'b0;
  endtask

  task automatic tx_drain_one();
    @(negedge clk);
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, tx_q.size() != 0});
    if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
    tx_ready = 1'b1;
    @(posedge clk);
    if (tx_q.size() != 0) void'(tx_q.pop_front());
    #1 tx_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r, e, d;
    logic [3:0]  s;
    int op;

    rst_n = 1'b0; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    m_ctrl = 0; m_ovf = 0; m_udf = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_soc_rst", {31'd0, soc_rst_n}, 32'd0);
    chk("rst_boot", {30'd0, boot_sel}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    do_status("status_reset");

    // CTRL write/read
    wb_write(32'h00, 32'h7, 4'h1); m_ctrl = 4'h7;
    chk("soc_rst_run", {31'd0, soc_rst_n}, 32'd1);
    chk("boot_sel", {30'd0, boot_sel}, 32'd3);
    wb_read(32'h00, r); chk("ctrl_rd", r, 32'h7);

    // Back-to-back request: ack alternates 1/0
    @(negedge clk);
    stb = 1; cyc = 1; we = 0; adr = 32'h00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("b2b_ack", {31'd0, ack}, {31'd0, (i % 2) == 0});
      chk("b2b_dat", dat_o, ((i % 2) == 0) ? {28'd0, m_ctrl} : 32'd0);
    end
    stb = 0; cyc = 0;
    @(posedge clk); #1;

    // sel[0]=0 leaves CTRL; unmapped offsets read 0 and ignore writes
    wb_write(32'h00, 32'hff, 4'h0);
    wb_read(32'h00, r); chk("ctrl_sel_gate", r, 32'h7);
    wb_write(32'h20, 32'hdead_beef, 4'hf);
    wb_read(32'h20, r); chk("unmapped_rd", r, 32'h0);
    wb_read(32'h08, r); chk("txdata_rd0", r, 32'h0);
    do_status("status_unmapped");

    wb_write(32'h00, 32'hf, 4'h1); m_ctrl = 4'hf;

    // TX overflow
    for (int i = 0; i < 5; i++) do_tx_write(32'ha0 + 32'(i));
    do_status("status_tx_ovf");
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", {31'd0, tx_valid}, 32'd1);
      chk("drain_data", tx_data, tx_q[0]);
      @(negedge clk);
      void'(tx_q.pop_front());
    end
    chk("drain_empty", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    do_status("status_drained");
    wb_write(32'h04, 32'h1000, 4'hf); m_ovf = 1'b0;
    do_status("status_w1c");

    // RX + irq
    soc_push(32'h11);
    chk("irq_lag", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_set", {31'd0, irq}, 32'd1);
    soc_push(32'h22);
    do_rx_read();
    chk("irq_hold", {31'd0, irq}, 32'd1);
    do_rx_read();
    chk("irq_clear", {31'd0, irq}, 32'd0);
    do_rx_read();
    do_status("status_udf");
    wb_write(32'h04, 32'h2000, 4'hf); m_udf = 1'b0;
    do_status("status_udf_clr");

    // RX full with simultaneous pop and SoC push attempt
    for (int i = 0; i < DEPTH; i++) soc_push(32'h50 + 32'(i));
    do_status("status_rx_full");
    @(negedge clk);
    chk("rx_ready_full", {31'd0, rx_ready}, 32'd0);
    rx_valid = 1; rx_data = 32'h99;
    stb = 1; cyc = 1; we = 0; adr = 32'h0c;
    @(posedge clk); #1;
    chk("full_pop_ack", {31'd0, ack}, 32'd1);
    m_rx_read(e);
    chk("full_pop_data", dat_o, e);
    chk("rx_ready_after_pop", {31'd0, rx_ready}, 32'd1);
    rx_valid = 0; stb = 0; cyc = 0;
    @(posedge clk); #1;
    do_status("status_no_push");
    repeat (DEPTH - 1) do_rx_read();

    // Reset during a pending ack with both FIFOs holding data
    do_tx_write(32'hc0);
    do_tx_write(32'hc1);
    soc_push(32'hd0);
    soc_push(32'hd1);
    @(negedge clk);
    stb = 1; cyc = 1; we = 0; adr = 32'h0c;
    @(posedge clk); #1;
    chk("mid_ack", {31'd0, ack}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    tx_q.delete(); rx_q.delete(); m_ctrl = 0; m_ovf = 0; m_udf = 0;
    chk("mid_rst_ack", {31'd0, ack}, 32'd0);
    chk("mid_rst_dat", dat_o, 32'd0);
    chk("mid_rst_soc", {31'd0, soc_rst_n}, 32'd0);
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    stb = 0; cyc = 0; rst_n = 1'b1;
    @(posedge clk); #1;
    do_status("status_after_rst");
    wb_read(32'h00, r); chk("ctrl_after_rst", r, 32'h0);

    // Randomized mix against the model
    wb_write(32'h00, 32'h9, 4'h1); m_ctrl = 4'h9;
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 6);
      d = $urandom;
      case (op)
        0: do_tx_write(d);
        1: do_rx_read();
        2: soc_push(d);
        3: tx_drain_one();
        4: begin
          do_status("rand_status");
          chk("rand_irq", {31'd0, irq}, {31'd0, m_ctrl[3] && rx_q.size() != 0});
        end
        5: begin
          s = 4'($urandom_range(0, 15));
          wb_write(32'h00, d, s);
          if (s[0]) m_ctrl = d[3:0];
          chk("rand_soc_rst", {31'd0, soc_rst_n}, {31'd0, m_ctrl[0]});
          chk("rand_boot", {30'd0, boot_sel}, {30'd0, m_ctrl[2:1]});
        end
        default: begin
          wb_write(32'h04, d, 4'hf);
          if (d[12]) m_ovf = 1'b0;
          if (d[13]) m_udf = 1'b0;
        end
      endcase
    end
    do_status("final_status");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
